// File: rtl/retry_ctrl_flit_packer_if.sv
// Control-flit output channel from the RETRY flit packer to the CRC generator.
// The packer drives the master side; the CRC generator drives the ready signal.
interface retry_ctrl_flit_packer_if;
  logic [511:0] o_ctrl_flit;
  logic         o_ctrl_flit_valid;
  logic         i_ctrl_flit_ready;

  modport master (
    output o_ctrl_flit,
    output o_ctrl_flit_valid,
    input  i_ctrl_flit_ready
  );

  modport slave (
    input  o_ctrl_flit,
    input  o_ctrl_flit_valid,
    output i_ctrl_flit_ready
  );
endinterface

// File: rtl/retry_ctrl_flit_packer.sv
// RETRY control-flit packer: emits 5 RETRY.Frame flits followed by a RETRY.Req or RETRY.Ack flit.
// Optional macro RETRY_PKR_STATS_EN adds saturating per-sequence statistics counters.
module retry_ctrl_flit_packer (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_pl_lnk_up,
  input  logic                            retry_send_req_seq,
  input  logic                            retry_send_ack_seq,
  input  logic [4:0]                      retry_num_retry,
  input  logic [4:0]                      retry_num_phy_reinit,
  input  logic [7:0]                      retry_eseq,
  input  logic [7:0]                      retry_wrt_ptr,
  input  logic [7:0]                      retry_num_free_buff,
  retry_ctrl_flit_packer_if.master        flit_if,
  output logic                            o_req_sent,
  output logic                            o_ack_sent,
  output logic                            o_busy,
  output logic [7:0]                      o_req_seq_cnt,
  output logic [7:0]                      o_ack_seq_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_FRAME = 3'd1,
    REQ       = 3'd2,
    ACK_FRAME = 3'd3,
    ACK       = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic         req_pend_q, req_pend_d;
  logic         ack_pend_q, ack_pend_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [4:0]   num_retry_q, num_retry_d;
  logic [4:0]   num_phy_reinit_q, num_phy_reinit_d;
  logic [7:0]   eseq_q, eseq_d;
  logic [7:0]   wrt_ptr_q, wrt_ptr_d;
  logic [7:0]   num_free_buff_q, num_free_buff_d;
  logic [511:0] flit_q, flit_d;
  logic         valid_q, valid_d;
  logic         req_sent_q, req_sent_d;
  logic         ack_sent_q, ack_sent_d;
  logic         hs;

  assign hs = valid_q & flit_if.i_ctrl_flit_ready;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    req_pend_d       = req_pend_q | retry_send_req_seq;
    ack_pend_d       = ack_pend_q | retry_send_ack_seq;
    num_retry_d      = num_retry_q;
    num_phy_reinit_d = num_phy_reinit_q;
    eseq_d           = eseq_q;
    wrt_ptr_d        = wrt_ptr_q;
    num_free_buff_d  = num_free_buff_q;
    req_sent_d       = 1'b0;
    ack_sent_d       = 1'b0;

    if (!i_pl_lnk_up) begin
      state_d    = IDLE;
      cnt_d      = 3'd0;
      req_pend_d = 1'b0;
      ack_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ack_pend_q || req_pend_q) begin
            // A request arriving in this same cycle re-arms the pending bit being consumed.
            num_retry_d      = retry_num_retry;
            num_phy_reinit_d = retry_num_phy_reinit;
            eseq_d           = retry_eseq;
            wrt_ptr_d        = retry_wrt_ptr;
            num_free_buff_d  = retry_num_free_buff;
            cnt_d            = 3'd0;
            if (ack_pend_q) begin
              state_d    = ACK_FRAME;
              ack_pend_d = retry_send_ack_seq;
            end else begin
              state_d    = REQ_FRAME;
              req_pend_d = retry_send_req_seq;
            end
          end
        end
        REQ_FRAME, ACK_FRAME: begin
          if (hs) begin
            if (cnt_q == 3'd4) begin
              state_d = (state_q == REQ_FRAME) ? REQ : ACK;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        REQ: begin
          if (hs) begin
            state_d    = IDLE;
            req_sent_d = 1'b1;
          end
        end
        ACK: begin
          if (hs) begin
            state_d    = IDLE;
            ack_sent_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Flit and valid are built from the next state so they are registered yet track the FSM exactly.
    valid_d = (state_d != IDLE);
    flit_d  = '0;
    if (state_d != IDLE) begin
      flit_d[0]   = 1'b1;
      flit_d[7:4] = 4'b0001;
      case (state_d)
        REQ_FRAME, ACK_FRAME: flit_d[11:8] = 4'b0011;
        REQ: begin
          flit_d[11:8]  = 4'b0001;
          flit_d[20:16] = num_retry_d;
          flit_d[28:24] = num_phy_reinit_d;
          flit_d[39:32] = eseq_d;
        end
        ACK: begin
          flit_d[11:8]  = 4'b0010;
          flit_d[20:16] = num_retry_d;
          flit_d[28:24] = num_phy_reinit_d;
          flit_d[39:32] = wrt_ptr_d;
          flit_d[47:40] = num_free_buff_d;
        end
        default: flit_d[11:8] = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= IDLE;
      req_pend_q       <= 1'b0;
      ack_pend_q       <= 1'b0;
      cnt_q            <= 3'd0;
      num_retry_q      <= 5'd0;
      num_phy_reinit_q <= 5'd0;
      eseq_q           <= 8'd0;
      wrt_ptr_q        <= 8'd0;
      num_free_buff_q  <= 8'd0;
      flit_q           <= '0;
      valid_q          <= 1'b0;
      req_sent_q       <= 1'b0;
      ack_sent_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_pend_q       <= req_pend_d;
      ack_pend_q       <= ack_pend_d;
      cnt_q            <= cnt_d;
      num_retry_q      <= num_retry_d;
      num_phy_reinit_q <= num_phy_reinit_d;
      eseq_q           <= eseq_d;
      wrt_ptr_q        <= wrt_ptr_d;
      num_free_buff_q  <= num_free_buff_d;
      flit_q           <= flit_d;
      valid_q          <= valid_d;
      req_sent_q       <= req_sent_d;
      ack_sent_q       <= ack_sent_d;
    end
  end

  assign flit_if.o_ctrl_flit       = flit_q;
  assign flit_if.o_ctrl_flit_valid = valid_q;
  assign o_req_sent                = req_sent_q;
  assign o_ack_sent                = ack_sent_q;
  assign o_busy                    = (state_q != IDLE) || req_pend_q || ack_pend_q;

`ifdef RETRY_PKR_STATS_EN
  logic [7:0] req_seq_cnt_q, req_seq_cnt_d;
  logic [7:0] ack_seq_cnt_q, ack_seq_cnt_d;

  always_comb begin
    req_seq_cnt_d = req_seq_cnt_q;
    ack_seq_cnt_d = ack_seq_cnt_q;
    if (req_sent_q && (req_seq_cnt_q != 8'hFF)) req_seq_cnt_d = req_seq_cnt_q + 8'd1;
    if (ack_sent_q && (ack_seq_cnt_q != 8'hFF)) ack_seq_cnt_d = ack_seq_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_seq_cnt_q <= 8'd0;
      ack_seq_cnt_q <= 8'd0;
    end else begin
      req_seq_cnt_q <= req_seq_cnt_d;
      ack_seq_cnt_q <= ack_seq_cnt_d;
    end
  end

  assign o_req_seq_cnt = req_seq_cnt_q;
  assign o_ack_seq_cnt = ack_seq_cnt_q;
`else
  assign o_req_seq_cnt = 8'd0;
  assign o_ack_seq_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_retry_ctrl_flit_packer.sv
// Scoreboard bench for retry_ctrl_flit_packer: stimulus pushes expected flits and sent pulses,
// a negedge monitor pops and compares them. Define RETRY_PKR_STATS_EN to exercise the counters.
module tb_retry_ctrl_flit_packer;

  logic       clk;
  logic       rst_n;
  logic       lnk_up;
  logic       send_req;
  logic       send_ack;
  logic [4:0] num_retry;
  logic [4:0] num_phy_reinit;
  logic [7:0] eseq;
  logic [7:0] wrt_ptr;
  logic [7:0] num_free_buff;
  logic       req_sent;
  logic       ack_sent;
  logic       busy;
  logic [7:0] req_seq_cnt;
  logic [7:0] ack_seq_cnt;

  retry_ctrl_flit_packer_if flit_if ();

  retry_ctrl_flit_packer dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_pl_lnk_up          (lnk_up),
    .retry_send_req_seq   (send_req),
    .retry_send_ack_seq   (send_ack),
    .retry_num_retry      (num_retry),
    .retry_num_phy_reinit (num_phy_reinit),
    .retry_eseq           (eseq),
    .retry_wrt_ptr        (wrt_ptr),
    .retry_num_free_buff  (num_free_buff),
    .flit_if              (flit_if),
    .o_req_sent           (req_sent),
    .o_ack_sent           (ack_sent),
    .o_busy               (busy),
    .o_req_seq_cnt        (req_seq_cnt),
    .o_ack_seq_cnt        (ack_seq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [511:0] flit_q[$];
  int           pulse_q[$];
  int           total = 0;
  int           bad = 0;
  int           prev_hs_sub = -1;
  int           exp_req_seqs = 0;
  int           exp_ack_seqs = 0;

  // Expected flit from the field map: subtype 3 = Frame, 1 = Req (b32 = Eseq), 2 = Ack (b32 = WrPtr, b40 = NumFreeBuf).
  function automatic logic [511:0] mk_flit(int sub, logic [4:0] nr, logic [4:0] npr,
                                           logic [7:0] b32, logic [7:0] b40);
    logic [511:0] f;
    f        = '0;
    f[0]     = 1'b1;
    f[7:4]   = 4'b0001;
    f[11:8]  = sub[3:0];
    if (sub != 3) begin
      f[20:16] = nr;
      f[28:24] = npr;
      f[39:32] = b32;
      if (sub == 2) f[47:40] = b40;
    end
    return f;
  endfunction

  task automatic push_seq(int kind, logic [4:0] nr, logic [4:0] npr, logic [7:0] b32, logic [7:0] b40);
    for (int i = 0; i < 5; i++) flit_q.push_back(mk_flit(3, nr, npr, b32, b40));
    flit_q.push_back(mk_flit(kind, nr, npr, b32, b40));
    pulse_q.push_back(kind);
    if (kind == 1) exp_req_seqs++;
    else exp_ack_seqs++;
  endtask

  task automatic check_output(string name, logic [63:0] actual, logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(logic req, logic ack);
    @(posedge clk);
    #1;
    send_req = req;
    send_ack = ack;
    @(posedge clk);
    #1;
    send_req = 1'b0;
    send_ack = 1'b0;
  endtask

  task automatic wait_valid(int budget);
    int n;
    n = 0;
    while (flit_if.o_ctrl_flit_valid !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (flit_if.o_ctrl_flit_valid !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_valid: valid=%b after %0d cycles, required 1", flit_if.o_ctrl_flit_valid, n);
    end
  endtask

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while ((flit_q.size() != 0 || pulse_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (flit_q.size() != 0 || pulse_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: flits_left=%0d pulses_left=%0d, required 0", flit_q.size(), pulse_q.size());
      flit_q.delete();
      pulse_q.delete();
    end
  endtask

  // Monitor: sent pulses must match the queued order and follow the matching final-flit handshake.
  always @(negedge clk) begin
    logic [511:0] exp_f;
    if (ack_sent === 1'b1) begin
      total++;
      if (pulse_q.size() == 0 || pulse_q[0] != 2 || prev_hs_sub != 2) begin
        bad++;
        $display("[TB] FAIL ack_sent: pulse seen, queued=%0d prev_handshake_sub=%0d, required 2/2",
                 (pulse_q.size() != 0) ? pulse_q[0] : 0, prev_hs_sub);
      end
      if (pulse_q.size() != 0) void'(pulse_q.pop_front());
    end
    if (req_sent === 1'b1) begin
      total++;
      if (pulse_q.size() == 0 || pulse_q[0] != 1 || prev_hs_sub != 1) begin
        bad++;
        $display("[TB] FAIL req_sent: pulse seen, queued=%0d prev_handshake_sub=%0d, required 1/1",
                 (pulse_q.size() != 0) ? pulse_q[0] : 0, prev_hs_sub);
      end
      if (pulse_q.size() != 0) void'(pulse_q.pop_front());
    end
    prev_hs_sub = -1;
    if (flit_if.o_ctrl_flit_valid === 1'b1 && flit_q.size() != 0) begin
      exp_f = flit_q[0];
      total++;
      if (flit_if.o_ctrl_flit !== exp_f) begin
        bad++;
        $display("[TB] FAIL flit: got low64=%0h upper_ok=%0b expected low64=%0h",
                 flit_if.o_ctrl_flit[63:0], (flit_if.o_ctrl_flit[511:64] === exp_f[511:64]), exp_f[63:0]);
      end
      if (flit_if.i_ctrl_flit_ready === 1'b1) begin
        prev_hs_sub = int'(exp_f[11:8]);
        void'(flit_q.pop_front());
      end
    end else if (flit_if.o_ctrl_flit_valid === 1'b1 && flit_if.i_ctrl_flit_ready === 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_flit: got handshake of low64=%0h, required none", flit_if.o_ctrl_flit[63:0]);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    lnk_up         = 1'b1;
    send_req       = 1'b0;
    send_ack       = 1'b0;
    num_retry      = 5'd0;
    num_phy_reinit = 5'd0;
    eseq           = 8'd0;
    wrt_ptr        = 8'd0;
    num_free_buff  = 8'd0;
    flit_if.i_ctrl_flit_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_valid", {63'd0, flit_if.o_ctrl_flit_valid}, 64'd0);
    check_output("rst_flit", flit_if.o_ctrl_flit[63:0], 64'd0);
    check_output("rst_busy", {63'd0, busy}, 64'd0);
    check_output("rst_pulses", {62'd0, req_sent, ack_sent}, 64'd0);
    check_output("rst_cnts", {48'd0, req_seq_cnt, ack_seq_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Req sequence, hand-computed flits: Frame = 0x311, Req = Eseq 0x5A, NUM_RETRY 3
    num_retry = 5'd3;
    eseq      = 8'h5A;
    for (int i = 0; i < 5; i++) flit_q.push_back(512'h311);
    flit_q.push_back(512'h5A_0003_0111);
    pulse_q.push_back(1);
    exp_req_seqs++;
    apply_stimulus(1'b1, 1'b0);
    check_output("busy_pending", {63'd0, busy}, 64'd1);
    wait_drain(40);

    // Simultaneous requests: Ack sequence first, then Req
    num_retry = 5'd1; num_phy_reinit = 5'd4; eseq = 8'h22; wrt_ptr = 8'h33; num_free_buff = 8'h44;
    push_seq(2, 5'd1, 5'd4, 8'h33, 8'h44);
    push_seq(1, 5'd1, 5'd4, 8'h22, 8'h00);
    apply_stimulus(1'b1, 1'b1);
    wait_drain(60);

    // Ack with 3-cycle stall on 2nd Frame; fields change mid-sequence
    num_retry = 5'd7; num_phy_reinit = 5'd2; wrt_ptr = 8'hC3; num_free_buff = 8'h10;
    push_seq(2, 5'd7, 5'd2, 8'hC3, 8'h10);
    apply_stimulus(1'b0, 1'b1);
    wait_valid(10);
    @(posedge clk);
    #1;
    flit_if.i_ctrl_flit_ready = 1'b0;
    num_retry = 5'd31; num_phy_reinit = 5'd31; wrt_ptr = 8'hFF; num_free_buff = 8'hEE; eseq = 8'hDD;
    repeat (3) @(posedge clk);
    #1;
    flit_if.i_ctrl_flit_ready = 1'b1;
    wait_drain(40);

    // Repeated requests during own sequence merge into one extra sequence
    num_retry = 5'd9; num_phy_reinit = 5'd0; eseq = 8'h81;
    push_seq(1, 5'd9, 5'd0, 8'h81, 8'h00);
    push_seq(1, 5'd9, 5'd0, 8'h81, 8'h00);
    apply_stimulus(1'b1, 1'b0);
    wait_valid(10);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    wait_drain(60);

    // Link drop while the 3rd Frame is presented
    flit_if.i_ctrl_flit_ready = 1'b0;
    num_retry = 5'd5; num_phy_reinit = 5'd1; eseq = 8'h77;
    flit_q.push_back(mk_flit(3, 5'd5, 5'd1, 8'h77, 8'h00));
    flit_q.push_back(mk_flit(3, 5'd5, 5'd1, 8'h77, 8'h00));
    apply_stimulus(1'b1, 1'b0);
    wait_valid(10);
    flit_if.i_ctrl_flit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flit_if.i_ctrl_flit_ready = 1'b0;
    check_output("lnk_third_frame_valid", {63'd0, flit_if.o_ctrl_flit_valid}, 64'd1);
    lnk_up = 1'b0;
    @(posedge clk);
    #1;
    check_output("lnk_down_valid", {63'd0, flit_if.o_ctrl_flit_valid}, 64'd0);
    check_output("lnk_down_busy", {63'd0, busy}, 64'd0);
    flit_if.i_ctrl_flit_ready = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    lnk_up = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("lnk_ignored_busy", {63'd0, busy}, 64'd0);
    check_output("lnk_ignored_valid", {63'd0, flit_if.o_ctrl_flit_valid}, 64'd0);

    // Full sequence after link recovery shows the frame counter was cleared
    num_retry = 5'd12; num_phy_reinit = 5'd6; eseq = 8'h3C;
    push_seq(1, 5'd12, 5'd6, 8'h3C, 8'h00);
    apply_stimulus(1'b1, 1'b0);
    wait_drain(40);

    // Reset asserted while the Req flit is stalled
    num_retry = 5'd2; num_phy_reinit = 5'd3; eseq = 8'h99;
    for (int i = 0; i < 5; i++) flit_q.push_back(mk_flit(3, 5'd2, 5'd3, 8'h99, 8'h00));
    apply_stimulus(1'b1, 1'b0);
    wait_valid(10);
    repeat (5) @(posedge clk);
    #1;
    flit_if.i_ctrl_flit_ready = 1'b0;
    check_output("req_state_flit", flit_if.o_ctrl_flit[63:0], 64'h99_0302_0111);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", {63'd0, flit_if.o_ctrl_flit_valid}, 64'd0);
    check_output("mid_rst_flit", flit_if.o_ctrl_flit[63:0], 64'd0);
    check_output("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_output("mid_rst_pulses", {62'd0, req_sent, ack_sent}, 64'd0);
    check_output("mid_rst_cnts", {48'd0, req_seq_cnt, ack_seq_cnt}, 64'd0);
    exp_req_seqs = 0;
    exp_ack_seqs = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    flit_if.i_ctrl_flit_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_output("post_rst_busy", {63'd0, busy}, 64'd0);

    // One Ack sequence so both counters have a known model value
    num_retry = 5'd4; num_phy_reinit = 5'd8; wrt_ptr = 8'h01; num_free_buff = 8'h02;
    push_seq(2, 5'd4, 5'd8, 8'h01, 8'h02);
    apply_stimulus(1'b0, 1'b1);
    wait_drain(40);

`ifdef RETRY_PKR_STATS_EN
    num_retry = 5'd0; num_phy_reinit = 5'd0; eseq = 8'h10;
    for (int s = 0; s < 256; s++) begin
      push_seq(1, 5'd0, 5'd0, 8'h10, 8'h00);
      apply_stimulus(1'b1, 1'b0);
      wait_drain(40);
    end
    repeat (2) @(posedge clk);
    #1;
    check_output("req_seq_cnt", {56'd0, req_seq_cnt}, (exp_req_seqs > 255) ? 64'd255 : 64'(exp_req_seqs));
    check_output("ack_seq_cnt", {56'd0, ack_seq_cnt}, (exp_ack_seqs > 255) ? 64'd255 : 64'(exp_ack_seqs));
`else
    repeat (2) @(posedge clk);
    #1;
    check_output("req_seq_cnt_off", {56'd0, req_seq_cnt}, 64'd0);
    check_output("ack_seq_cnt_off", {56'd0, ack_seq_cnt}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retry_ctrl_flit_packer.md
RETRY_CTRL_FLIT_PACKER -- requirements
Module: retry_ctrl_flit_packer

Interface
REQ-001 SHALL have `i_clk`, input, 1 bit, the single clock; all state is on its rising edge.
REQ-002 SHALL have `i_rst_n`, input, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have `i_pl_lnk_up`, input, 1 bit: PHY link up.
REQ-004 SHALL have `retry_send_req_seq`, input, 1 bit: one-cycle request to send a RETRY.Req sequence.
REQ-005 SHALL have `retry_send_ack_seq`, input, 1 bit: one-cycle request to send a RETRY.Ack sequence.
REQ-006 SHALL have `retry_num_retry`, input, 5 bits: NUM_RETRY field.
REQ-007 SHALL have `retry_num_phy_reinit`, input, 5 bits: NUM_PHY_REINIT field.
REQ-008 SHALL have `retry_eseq`, input, 8 bits: expected sequence number, used by Req.
REQ-009 SHALL have `retry_wrt_ptr`, input, 8 bits: write pointer, used by Ack.
REQ-010 SHALL have `retry_num_free_buff`, input, 8 bits: free-buffer count, used by Ack.
REQ-011 SHALL have `i_ctrl_flit_ready`, input, 1 bit: downstream accepts the flit.
REQ-012 SHALL have `o_ctrl_flit`, output, 512 bits: control flit without CRC, sent to the CRC generator.
REQ-013 SHALL have `o_ctrl_flit_valid`, output, 1 bit: flit valid.
REQ-014 SHALL have `o_req_sent` and `o_ack_sent`, outputs, 1 bit each: one-cycle completion pulses sent to the controller.
REQ-015 SHALL have `o_busy`, output, 1 bit: a sequence is in progress or pending.
REQ-016 SHALL have `o_req_seq_cnt` and `o_ack_seq_cnt`, outputs, 8 bits each: statistics counters (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, REQ_FRAME, REQ, ACK_FRAME, ACK.
REQ-018 SHALL latch each request in a pending bit (`req_pend`, `ack_pend`); a request arriving during a sequence SHALL be kept and serviced afterwards.
REQ-019 In IDLE with `ack_pend` set, SHALL move to ACK_FRAME; otherwise with `req_pend` set, SHALL move to REQ_FRAME. Ack has priority.
REQ-020 On leaving IDLE, SHALL snapshot all field inputs and clear the chosen pending bit; every flit of that sequence SHALL use the snapshot.
REQ-021 REQ_FRAME and ACK_FRAME SHALL each emit exactly 5 RETRY.Frame flits, counted by a 3-bit counter that advances only on handshake.
REQ-022 After the 5th Frame handshake, SHALL move to REQ (or ACK); that state SHALL emit one flit, then return to IDLE on handshake.
REQ-023 A handshake SHALL be `o_ctrl_flit_valid` && `i_ctrl_flit_ready`; valid SHALL be high in every non-IDLE state.
REQ-024 `o_ctrl_flit` SHALL hold stable while valid is high and ready is low.
REQ-025 Flit fields: [0]=1 (control flit); [7:4]=4'b0001 (RETRY); [11:8]=subtype (Idle 0000, Req 0001, Ack 0010, Frame 0011).
REQ-026 Req payload: [20:16]=NUM_RETRY, [28:24]=NUM_PHY_REINIT, [39:32]=Eseq.
REQ-027 Ack payload: [20:16]=NUM_RETRY, [28:24]=NUM_PHY_REINIT, [39:32]=WrPtr, [47:40]=NumFreeBuf.
REQ-028 Frame payload, and all bits not defined in REQ-025 to REQ-027, SHALL be 0.
REQ-029 `o_req_sent` and `o_ack_sent` SHALL pulse, registered, in the cycle after the Req or Ack handshake respectively.
REQ-030 When `i_pl_lnk_up`=0, SHALL force IDLE, clear both pending bits and the frame counter, and ignore new requests; valid SHALL go low in the next cycle.
REQ-031 If both requests arrive in the same cycle, SHALL latch both, send Ack first, then Req.
REQ-032 A request arriving while its own sequence is in progress SHALL be latched once; repeated requests SHALL merge into a single pending bit.
REQ-033 `o_busy` = (state != IDLE) || `req_pend` || `ack_pend`.

Reset
REQ-034 While `i_rst_n`=0, SHALL force: state IDLE, pending bits 0, counter 0, `o_ctrl_flit`=0, valid 0, sent pulses 0, `o_busy` 0, statistics counters 0.
REQ-035 Reset asserted mid-sequence SHALL abort it with no sent pulse.

Configuration
REQ-036 Macro RETRY_PKR_STATS_EN, when defined: `o_req_seq_cnt` and `o_ack_seq_cnt` SHALL increment, saturating at 255, on each `o_req_sent` or `o_ack_sent` pulse.
REQ-037 When RETRY_PKR_STATS_EN is undefined, both counters SHALL be tied to 0 and no counter flops SHALL be built.

Verification
REQ-038 Req pulse with eseq=0x5A, num_retry=3, ready=1 -> 5 Frame flits ([11:8]=3), then Req flit with [39:32]=0x5A and [20:16]=3; `o_req_sent` pulses 1 cycle later.
REQ-039 Req and Ack pulsed in the same cycle -> 6 Ack-sequence flits first, then 6 Req-sequence flits; `o_ack_sent` before `o_req_sent`.
REQ-040 Ack sequence with ready low for 3 cycles on the 2nd Frame -> flit held stable, exactly 5 Frames; inputs changed mid-sequence do not alter the snapshot.
REQ-041 `i_pl_lnk_up` dropped at the 3rd Frame -> valid 0 the next cycle, no sent pulse, `o_busy`=0.
REQ-042 `i_rst_n` low during the Req state -> all outputs 0 immediately; with RETRY_PKR_STATS_EN, 256 Req sequences -> `o_req_seq_cnt`=255.
